std_fp_mult_pipe_hs: RTL and testbench

//  Parametrised fixed-point multiplier; valid/ready handshake on both sides, configurable pipeline depth.

---
 rtl/std_fp_pkg.sv | 29 ++
 rtl/std_fp_mult_pipe_hs_if.sv | 24 ++
 rtl/std_fp_round_sat.sv | 41 ++++
 rtl/std_fp_mult_pipe_hs.sv | 107 ++++++++++
 tb/tb_std_fp_mult_pipe_hs.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/std_fp_pkg.sv
// Shared types and helpers for the std_* fixed-point arithmetic primitives.
// Saturation limits are returned wide and sliced to the width by the caller.
package std_fp_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_t;

  localparam int FP_MAX_W = 128;
  typedef logic [FP_MAX_W-1:0] fp_word_t;

  // Largest representable code: 0111..1 when signed, 1111..1 when unsigned.
  function automatic fp_word_t fp_sat_max(input int width, input bit is_signed);
    fp_word_t v = '0;
    for (int i = 0; i < FP_MAX_W; i++) begin
      if (i < width - int'(is_signed)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Smallest representable code: 1000..0 when signed, 0 when unsigned.
  function automatic fp_word_t fp_sat_min(input int width, input bit is_signed);
    fp_word_t v = '0;
    if (is_signed && width > 0) v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/std_fp_mult_pipe_hs_if.sv
// Valid/ready operand and result channels of the pipelined fixed-point multiplier.
// The slave modport is the multiplier; the master is the producer/consumer around it.
interface std_fp_mult_pipe_hs_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             overflow;

  modport master (
    output in_valid, left, right, out_ready,
    input  in_ready, out_valid, out, overflow
  );

  modport slave (
    input  in_valid, left, right, out_ready,
    output in_ready, out_valid, out, overflow
  );
endinterface

// File: rtl/std_fp_round_sat.sv
// Combinational post-processing of a double-width fixed-point product:
// optional half-up rounding, slice back to WIDTH bits, overflow detect and clamp.
module std_fp_round_sat
  import std_fp_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          FRAC_WIDTH = 16,
  parameter bit          SIGNED     = 1'b0,
  parameter round_mode_t ROUND_MODE = RND_TRUNC,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic [2*WIDTH-1:0] p,
  output logic               overflow,
  output logic [WIDTH-1:0]   result
);
  localparam int RW     = 2 * WIDTH + 1;
  localparam int HI_W   = RW - FRAC_WIDTH - WIDTH;
  localparam int RND_SH = (FRAC_WIDTH > 0) ? FRAC_WIDTH - 1 : 0;
  localparam logic [RW-1:0] RND_ADD =
    (ROUND_MODE == RND_HALF_UP && FRAC_WIDTH > 0) ? (RW'(1) << RND_SH) : '0;
  localparam fp_word_t SAT_MAX = fp_sat_max(WIDTH, SIGNED);
  localparam fp_word_t SAT_MIN = fp_sat_min(WIDTH, SIGNED);

  logic [RW-1:0]    r;
  logic [WIDTH-1:0] out_raw;
  logic [HI_W:0]    top_bits;   // discarded high bits plus the kept MSB

  // NOTE: every output of this always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    r        = {(SIGNED && p[2*WIDTH-1]), p} + RND_ADD;
    out_raw  = r[FRAC_WIDTH +: WIDTH];
    top_bits = r[RW-1 -: HI_W+1];
    if (SIGNED) overflow = !((&top_bits) || !(|top_bits));
    else        overflow = |top_bits[HI_W:1];
    result = out_raw;
    if (SATURATE && overflow) begin
      result = (SIGNED && p[2*WIDTH-1]) ? SAT_MIN[WIDTH-1:0] : SAT_MAX[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/std_fp_mult_pipe_hs.sv
// Pipelined fixed-point multiplier with valid/ready on both sides and full back-pressure.
// Stage 0 registers operands, stage 1 the raw product, middle stages are retiming slots.
module std_fp_mult_pipe_hs
  import std_fp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int INT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 16,
  parameter int SIGNED     = 0,
  parameter int STAGES     = 3,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 0
) (
  input logic                  clk,
  input logic                  reset,
  std_fp_mult_pipe_hs_if.slave bus
);
  localparam int PW = 2 * WIDTH;

  if (WIDTH != INT_WIDTH + FRAC_WIDTH) begin : g_bad_width
    $fatal(1, "std_fp_mult_pipe_hs: WIDTH must equal INT_WIDTH + FRAC_WIDTH");
  end
  if (STAGES < 2) begin : g_bad_stages
    $fatal(1, "std_fp_mult_pipe_hs: STAGES must be at least 2");
  end
  if (FRAC_WIDTH < 0 || FRAC_WIDTH >= WIDTH) begin : g_bad_frac
    $fatal(1, "std_fp_mult_pipe_hs: FRAC_WIDTH must lie in 0..WIDTH-1");
  end

  logic [STAGES-1:0] vld;
  logic              adv;

  // The whole pipe moves as one: it only freezes when the output is held.
  assign adv          = ~vld[STAGES-1] | bus.out_ready;
  assign bus.in_ready = adv;
  assign bus.out_valid = vld[STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)    vld <= '0;
    else if (adv) vld <= {vld[STAGES-2:0], bus.in_valid};
  end

  logic [WIDTH-1:0] a_q, b_q;

  // NOTE: datapath registers are left unreset; the valid bits alone give them meaning.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_q <= bus.left;
      b_q <= bus.right;
    end
  end

  logic [PW-1:0] a_ext, b_ext, p_comb, p_last;

  assign a_ext  = (SIGNED != 0) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext  = (SIGNED != 0) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign p_comb = a_ext * b_ext;

  for (genvar k = 1; k <= STAGES - 2; k++) begin : g_dly
    logic [PW-1:0] p_q;
    if (k == 1) begin : g_first
      always_ff @(posedge clk) if (adv) p_q <= p_comb;
    end else begin : g_next
      always_ff @(posedge clk) if (adv) p_q <= g_dly[k-1].p_q;
    end
  end

  if (STAGES == 2) begin : g_p_direct
    assign p_last = p_comb;
  end else begin : g_p_piped
    assign p_last = g_dly[STAGES-2].p_q;
  end

  logic [WIDTH-1:0] res;
  logic             res_ovf;

  std_fp_round_sat #(
    .WIDTH      (WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH),
    .SIGNED     (SIGNED != 0),
    .ROUND_MODE ((ROUND != 0) ? RND_HALF_UP : RND_TRUNC),
    .SATURATE   (SATURATE != 0)
  ) u_round_sat (
    .p        (p_last),
    .overflow (res_ovf),
    .result   (res)
  );

  logic [WIDTH-1:0] out_q;
  logic             ovf_q;

  // Bubbles never overwrite the result, so out keeps the last valid value.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else if (adv && vld[STAGES-2]) begin
      out_q <= res;
      ovf_q <= res_ovf;
    end
  end

  assign bus.out      = out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_std_fp_mult_pipe_hs.sv
// Self-checking bench: four multiplier configurations side by side, each checked
// against an integer-range reference model and directed fixed-point cases.
module tb_std_fp_mult_pipe_hs;
  localparam int W     = 32;
  localparam int N_DUT = 4;
  localparam int C_FRAC   [N_DUT] = '{16, 16, 16, 0};
  localparam int C_SIGNED [N_DUT] = '{0, 1, 0, 1};
  localparam int C_ROUND  [N_DUT] = '{0, 0, 1, 1};
  localparam int C_SAT    [N_DUT] = '{0, 1, 0, 1};
  localparam int C_STAGES [N_DUT] = '{3, 3, 3, 5};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid  [N_DUT];
  logic         out_ready [N_DUT];
  logic [W-1:0] left_d    [N_DUT];
  logic [W-1:0] right_d   [N_DUT];
  logic         in_ready  [N_DUT];
  logic         out_valid [N_DUT];
  logic         overflow  [N_DUT];
  logic [W-1:0] out_d     [N_DUT];

  int total = 0;
  int bad   = 0;

  std_fp_mult_pipe_hs_if #(.WIDTH(W)) bus [N_DUT] ();

  for (genvar i = 0; i < N_DUT; i++) begin : g_conn
    assign bus[i].in_valid  = in_valid[i];
    assign bus[i].out_ready = out_ready[i];
    assign bus[i].left      = left_d[i];
    assign bus[i].right     = right_d[i];
    assign in_ready[i]      = bus[i].in_ready;
    assign out_valid[i]     = bus[i].out_valid;
    assign overflow[i]      = bus[i].overflow;
    assign out_d[i]         = bus[i].out;
  end

  std_fp_mult_pipe_hs #(.WIDTH(W), .INT_WIDTH(W - C_FRAC[0]), .FRAC_WIDTH(C_FRAC[0]),
    .SIGNED(C_SIGNED[0]), .STAGES(C_STAGES[0]), .ROUND(C_ROUND[0]), .SATURATE(C_SAT[0]))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus[0]));
  std_fp_mult_pipe_hs #(.WIDTH(W), .INT_WIDTH(W - C_FRAC[1]), .FRAC_WIDTH(C_FRAC[1]),
    .SIGNED(C_SIGNED[1]), .STAGES(C_STAGES[1]), .ROUND(C_ROUND[1]), .SATURATE(C_SAT[1]))
    u_dut1 (.clk(clk), .reset(reset), .bus(bus[1]));
  std_fp_mult_pipe_hs #(.WIDTH(W), .INT_WIDTH(W - C_FRAC[2]), .FRAC_WIDTH(C_FRAC[2]),
    .SIGNED(C_SIGNED[2]), .STAGES(C_STAGES[2]), .ROUND(C_ROUND[2]), .SATURATE(C_SAT[2]))
    u_dut2 (.clk(clk), .reset(reset), .bus(bus[2]));
  std_fp_mult_pipe_hs #(.WIDTH(W), .INT_WIDTH(W - C_FRAC[3]), .FRAC_WIDTH(C_FRAC[3]),
    .SIGNED(C_SIGNED[3]), .STAGES(C_STAGES[3]), .ROUND(C_ROUND[3]), .SATURATE(C_SAT[3]))
    u_dut3 (.clk(clk), .reset(reset), .bus(bus[3]));

  // Reference: exact integer product, scaled by floor division, then range-checked.
  function automatic logic [W:0] ref_mult(input int d, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [129:0] pa, pb, rc, q, hi, lo;
    logic [W-1:0] o;
    logic ovf;
    pa = (C_SIGNED[d] != 0) ? {{98{a[W-1]}}, a} : {98'd0, a};
    pb = (C_SIGNED[d] != 0) ? {{98{b[W-1]}}, b} : {98'd0, b};
    rc = '0;
    if (C_ROUND[d] != 0 && C_FRAC[d] > 0) rc[C_FRAC[d]-1] = 1'b1;
    q = (pa * pb + rc) >>> C_FRAC[d];
    if (C_SIGNED[d] != 0) begin
      hi = (130'sd1 <<< (W - 1)) - 130'sd1;
      lo = -(130'sd1 <<< (W - 1));
    end else begin
      hi = (130'sd1 <<< W) - 130'sd1;
      lo = '0;
    end
    ovf = (q > hi) || (q < lo);
    o   = q[W-1:0];
    if (C_SAT[d] != 0 && ovf) o = (q > hi) ? hi[W-1:0] : lo[W-1:0];
    return {ovf, o};
  endfunction

  function automatic logic [W-1:0] rand_op(input int d);
    logic [W-1:0] v;
    int sh;
    v  = $urandom;
    sh = $urandom_range(31);
    if (C_SIGNED[d] != 0) return W'($signed(v) >>> sh);
    return v >> sh;
  endfunction

  task automatic single(input int d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_o, input logic exp_v, input string name);
    int lat = 0;
    bit seen = 0;
    @(negedge clk);
    in_valid[d] = 1'b1; left_d[d] = a; right_d[d] = b; out_ready[d] = 1'b1;
    #1;
    total++;
    if (in_ready[d] !== 1'b1) begin
      bad++; $display("FAIL %s in_ready got=%b want=1", name, in_ready[d]);
    end
    while (!seen && lat < 20) begin
      @(negedge clk); lat++; in_valid[d] = 1'b0; #1;
      if (out_valid[d] === 1'b1) seen = 1;
    end
    total++;
    if (!seen || lat != C_STAGES[d]) begin
      bad++; $display("FAIL %s latency got=%0d seen=%0b want=%0d", name, lat, seen, C_STAGES[d]);
    end
    total++;
    if (out_d[d] !== exp_o || overflow[d] !== exp_v) begin
      bad++; $display("FAIL %s result got=%h/%b want=%h/%b", name, out_d[d], overflow[d], exp_o, exp_v);
    end
    @(negedge clk); #1;
    total++;
    if (out_valid[d] !== 1'b0) begin
      bad++; $display("FAIL %s drained out_valid got=%b want=0", name, out_valid[d]);
    end
  endtask

  task automatic stream(input int d, input int n, input int in_pct, input int rdy_pct,
                        input bit bp_mode, input string name, output int cycles);
    logic [W:0] exp_q[$];
    logic [W:0] e;
    logic [W-1:0] last_o;
    logic last_v;
    int got = 0, cyc = 0, issued = 0;
    bit acc = 0, stall = 0, extra = 0;
    while (got < n && cyc < n * 20 + 200) begin
      @(negedge clk); cyc++;
      if (acc) in_valid[d] = 1'b0;
      if (!in_valid[d] && issued < n && $urandom_range(99) < in_pct) begin
        in_valid[d] = 1'b1; left_d[d] = rand_op(d); right_d[d] = rand_op(d); issued++;
      end
      out_ready[d] = bp_mode ? !(cyc >= 4 && cyc <= 9) : ($urandom_range(99) < rdy_pct);
      #1;
      if (bp_mode) begin
        total++;
        if (in_ready[d] !== !(cyc >= 4 && cyc <= 9)) begin
          bad++; $display("FAIL %s in_ready cyc=%0d got=%b", name, cyc, in_ready[d]);
        end
      end else if (out_ready[d]) begin
        total++;
        if (in_ready[d] !== 1'b1) begin
          bad++; $display("FAIL %s in_ready with out_ready got=%b want=1", name, in_ready[d]);
        end
      end
      if (stall) begin
        total++;
        if (out_valid[d] !== 1'b1 || out_d[d] !== last_o || overflow[d] !== last_v) begin
          bad++; $display("FAIL %s hold got=%b/%h/%b want=1/%h/%b", name,
                          out_valid[d], out_d[d], overflow[d], last_o, last_v);
        end
      end
      stall = 0;
      if (out_valid[d] === 1'b1) begin
        if (out_ready[d]) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL %s unexpected output %h", name, out_d[d]);
          end else begin
            e = exp_q.pop_front();
            if ({overflow[d], out_d[d]} !== e) begin
              bad++; $display("FAIL %s item %0d got=%b/%h want=%b/%h", name, got,
                              overflow[d], out_d[d], e[W], e[W-1:0]);
            end
          end
          got++;
        end else begin
          stall = 1; last_o = out_d[d]; last_v = overflow[d];
        end
      end
      acc = in_valid[d] && in_ready[d];
      if (acc) exp_q.push_back(ref_mult(d, left_d[d], right_d[d]));
    end
    cycles = cyc;
    total++;
    if (got < n) begin
      bad++; $display("FAIL %s timeout got=%0d want=%0d", name, got, n);
    end
    in_valid[d] = 1'b0; out_ready[d] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (out_valid[d] === 1'b1) extra = 1;
    end
    total++;
    if (extra) begin
      bad++; $display("FAIL %s extra output after stream", name);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < N_DUT; d++) begin
      total++;
      if (out_valid[d] !== 1'b0 || out_d[d] !== '0 || overflow[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        bad++; $display("FAIL reset dut%0d got v=%b o=%h ov=%b rdy=%b want 0/0/0/1",
                        d, out_valid[d], out_d[d], overflow[d], in_ready[d]);
      end
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    single(0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, "u_1p5x2");
  endtask

  task automatic test_signed();
    single(1, 32'hFFFE_8000, 32'h0002_0000, 32'hFFFD_0000, 1'b0, "s_neg1p5x2");
    single(1, 32'h0100_0000, 32'h0100_0000, 32'h7FFF_FFFF, 1'b1, "s_sat_pos");
  endtask

  task automatic test_round();
    single(0, 32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 1'b0, "trunc_half");
    single(2, 32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0, "round_half");
  endtask

  task automatic test_back_pressure();
    int cyc;
    stream(0, 8, 100, 100, 1'b1, "bp", cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    stream(1, 16, 100, 100, 1'b0, "b2b", cyc);
    total++;
    if (cyc != 16 + C_STAGES[1]) begin
      bad++; $display("FAIL b2b throughput cycles got=%0d want=%0d", cyc, 16 + C_STAGES[1]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); out_ready[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1; left_d[0] = 32'h0003_0000 + W'(i); right_d[0] = 32'h0005_0000;
      @(negedge clk);
    end
    #1;
    total++;
    if (out_valid[0] !== 1'b1 || out_d[0] !== 32'h000F_0000) begin
      bad++; $display("FAIL rst_mid pre got=%b/%h want=1/000f0000", out_valid[0], out_d[0]);
    end
    reset = 1'b1; in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    @(negedge clk); #1;
    total++;
    if (out_valid[0] !== 1'b0 || out_d[0] !== '0 || overflow[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      bad++; $display("FAIL rst_mid got v=%b o=%h ov=%b rdy=%b want 0/0/0/1",
                      out_valid[0], out_d[0], overflow[0], in_ready[0]);
    end
    reset = 1'b0;
    single(0, 32'h0002_8000, 32'h0002_8000, 32'h0006_4000, 1'b0, "rst_mid_fresh");
  endtask

  task automatic test_random();
    int cyc;
    logic [W-1:0] a, b;
    logic [W:0] e;
    for (int d = 0; d < 3; d++) stream(d, 40, 80, 70, 1'b0, "rand_small", cyc);
    stream(3, 200, 70, 60, 1'b0, "rand_s5", cyc);
    a = rand_op(3); b = rand_op(3);
    e = ref_mult(3, a, b);
    single(3, a, b, e[W-1:0], e[W], "s5_latency");
  endtask

  initial begin
    for (int i = 0; i < N_DUT; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; left_d[i] = '0; right_d[i] = '0;
    end
    test_reset();
    test_basic();
    test_signed();
    test_round();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
